// File: rtl/hp_manager_param_if.sv
// Round handshake and HP/result status bundle between the win/lose judge,
// the HP manager and the result/display logic.
interface hp_manager_param_if #(
  parameter int HP_W  = 4,
  parameter int DB_W  = 36,
  parameter int CNT_W = 8
);
  logic             ROUND_VALID;
  logic [1:0]       ROUND_RES;
  logic [DB_W-1:0]  DB_IN;
  logic             RESTART;
  logic [HP_W-1:0]  MY_HP;
  logic [HP_W-1:0]  ENEMY_HP;
  logic [1:0]       RESULT;
  logic             GAME_OVER;
  logic             ROUND_BUSY;
  logic             ROUND_ACK;
  logic [CNT_W-1:0] ROUNDS;

  modport master (
    output ROUND_VALID, ROUND_RES, DB_IN, RESTART,
    input  MY_HP, ENEMY_HP, RESULT, GAME_OVER, ROUND_BUSY, ROUND_ACK, ROUNDS
  );

  modport slave (
    input  ROUND_VALID, ROUND_RES, DB_IN, RESTART,
    output MY_HP, ENEMY_HP, RESULT, GAME_OVER, ROUND_BUSY, ROUND_ACK, ROUNDS
  );
endinterface

// File: rtl/hp_manager_param.sv
// Parametrised hit-point manager: applies per-round damage taken from the
// problem word's level field and latches the match outcome until restart.
//
//   state | meaning
//   PLAY  | idle, waiting for a round verdict
//   APPLY | subtract latched damage from the loser(s), pulse ACK
//   CHECK | evaluate HP for a knock-out
//   OVER  | outcome held until RESTART or RST
module hp_manager_param #(
  parameter int HP_W     = 4,
  parameter int HP_INIT  = 10,
  parameter int DB_W     = 36,
  parameter int LVL_MSB  = 35,
  parameter int LVL_LSB  = 34,
  parameter int MIN_DMG  = 1,
  parameter int DRAW_DMG = 0,
  parameter int CNT_W    = 8
) (
  input  logic CLK,
  input  logic RST,
  hp_manager_param_if.slave bus
);
  localparam int LVL_W = LVL_MSB - LVL_LSB + 1;

  localparam logic [1:0] RES_NONE  = 2'b00;
  localparam logic [1:0] RES_SELF  = 2'b01;
  localparam logic [1:0] RES_OPP   = 2'b10;
  localparam logic [1:0] RES_DRAW  = 2'b11;

  localparam logic [HP_W-1:0] HP_RELOAD = HP_W'(HP_INIT);
  localparam logic [HP_W-1:0] DMG_MIN   = HP_W'(MIN_DMG);
  localparam logic            DRAW_HITS = (DRAW_DMG != 0);

  typedef enum logic [1:0] {PLAY, APPLY, CHECK, OVER} state_t;

  state_t           state;
  logic [HP_W-1:0]  my_hp;
  logic [HP_W-1:0]  enemy_hp;
  logic [HP_W-1:0]  dmg_q;
  logic [1:0]       res_q;
  logic [1:0]       result;
  logic             game_over;
  logic             round_busy;
  logic             round_ack;
  logic [CNT_W-1:0] rounds;

  logic [LVL_W-1:0] lvl_field;
  logic [HP_W-1:0]  dmg_in;
  logic             accept;
  logic             hit_enemy;
  logic             hit_me;
  logic             my_zero;
  logic             enemy_zero;

  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp,
                                               input logic [HP_W-1:0] dmg);
    return (hp <= dmg) ? '0 : hp - dmg;
  endfunction

  assign lvl_field = bus.DB_IN[LVL_MSB:LVL_LSB];

  // Level 0 problems still cost something so a round is never free.
  always_comb begin
    dmg_in = HP_W'(lvl_field);
    if (lvl_field == '0) begin
      dmg_in = DMG_MIN;
    end
  end

  // A draw is only a real round when draws deal damage; otherwise it is
  // treated exactly like "no result".
  always_comb begin
    accept = 1'b0;
    if (bus.ROUND_VALID && (bus.ROUND_RES != RES_NONE)) begin
      accept = (bus.ROUND_RES != RES_DRAW) || DRAW_HITS;
    end
  end

  assign hit_enemy  = (res_q == RES_SELF) || ((res_q == RES_DRAW) && DRAW_HITS);
  assign hit_me     = (res_q == RES_OPP)  || ((res_q == RES_DRAW) && DRAW_HITS);
  assign my_zero    = (my_hp == '0);
  assign enemy_zero = (enemy_hp == '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= PLAY;
      my_hp      <= HP_RELOAD;
      enemy_hp   <= HP_RELOAD;
      dmg_q      <= '0;
      res_q      <= RES_NONE;
      result     <= RES_NONE;
      game_over  <= 1'b0;
      round_busy <= 1'b0;
      round_ack  <= 1'b0;
      rounds     <= '0;
    end else if (bus.RESTART) begin
      // Restart wins over everything, including a round in flight.
      state      <= PLAY;
      my_hp      <= HP_RELOAD;
      enemy_hp   <= HP_RELOAD;
      dmg_q      <= '0;
      res_q      <= RES_NONE;
      result     <= RES_NONE;
      game_over  <= 1'b0;
      round_busy <= 1'b0;
      round_ack  <= 1'b0;
      rounds     <= '0;
    end else begin
      round_ack <= 1'b0;
      case (state)
        PLAY: begin
          if (accept) begin
            res_q      <= bus.ROUND_RES;
            dmg_q      <= dmg_in;
            round_busy <= 1'b1;
            state      <= APPLY;
          end
        end
        APPLY: begin
          if (hit_enemy) begin
            enemy_hp <= sat_sub(enemy_hp, dmg_q);
          end
          if (hit_me) begin
            my_hp <= sat_sub(my_hp, dmg_q);
          end
          if (rounds != '1) begin
            rounds <= rounds + 1'b1;
          end
          round_ack <= 1'b1;
          state     <= CHECK;
        end
        CHECK: begin
          if (my_zero && enemy_zero) begin
            result <= RES_DRAW;
          end else if (enemy_zero) begin
            result <= RES_SELF;
          end else if (my_zero) begin
            result <= RES_OPP;
          end
          if (my_zero || enemy_zero) begin
            game_over <= 1'b1;
            state     <= OVER;
          end else begin
            round_busy <= 1'b0;
            state      <= PLAY;
          end
        end
        OVER: begin
          state <= OVER;
        end
        default: begin
          state      <= PLAY;
          round_busy <= 1'b0;
        end
      endcase
    end
  end

  assign bus.MY_HP      = my_hp;
  assign bus.ENEMY_HP   = enemy_hp;
  assign bus.RESULT     = result;
  assign bus.GAME_OVER  = game_over;
  assign bus.ROUND_BUSY = round_busy;
  assign bus.ROUND_ACK  = round_ack;
  assign bus.ROUNDS     = rounds;
endmodule

// File: tb/tb_hp_manager_param.sv
// Directed bench for hp_manager_param: one DUT with draws harmless (A) and
// one with draws damaging both players (B), fed the same round stream.
module tb_hp_manager_param;
  logic        clk;
  logic        rst;
  logic        valid;
  logic [1:0]  res;
  logic [35:0] db;
  logic        restart;

  int checks   = 0;
  int failures = 0;

  hp_manager_param_if #(.HP_W(4), .DB_W(36), .CNT_W(8)) if_a ();
  hp_manager_param_if #(.HP_W(4), .DB_W(36), .CNT_W(8)) if_b ();

  assign if_a.ROUND_VALID = valid;
  assign if_a.ROUND_RES   = res;
  assign if_a.DB_IN       = db;
  assign if_a.RESTART     = restart;
  assign if_b.ROUND_VALID = valid;
  assign if_b.ROUND_RES   = res;
  assign if_b.DB_IN       = db;
  assign if_b.RESTART     = restart;

  hp_manager_param #(.DRAW_DMG(0)) dut_a (.CLK(clk), .RST(rst), .bus(if_a.slave));
  hp_manager_param #(.DRAW_DMG(1)) dut_b (.CLK(clk), .RST(rst), .bus(if_b.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // sel 0 -> DUT A, 1 -> DUT B
  task automatic chk_state(input string tag, input bit sel, input int my, input int en,
                           input int rs, input int go, input int bz, input int ak,
                           input int rn);
    int g_my, g_en, g_rs, g_go, g_bz, g_ak, g_rn;
    if (sel) begin
      g_my = int'(if_b.MY_HP); g_en = int'(if_b.ENEMY_HP); g_rs = int'(if_b.RESULT);
      g_go = int'(if_b.GAME_OVER); g_bz = int'(if_b.ROUND_BUSY);
      g_ak = int'(if_b.ROUND_ACK); g_rn = int'(if_b.ROUNDS);
    end else begin
      g_my = int'(if_a.MY_HP); g_en = int'(if_a.ENEMY_HP); g_rs = int'(if_a.RESULT);
      g_go = int'(if_a.GAME_OVER); g_bz = int'(if_a.ROUND_BUSY);
      g_ak = int'(if_a.ROUND_ACK); g_rn = int'(if_a.ROUNDS);
    end
    chk($sformatf("%s%s.my_hp", tag, sel ? "_b" : "_a"), g_my, my);
    chk($sformatf("%s%s.enemy_hp", tag, sel ? "_b" : "_a"), g_en, en);
    chk($sformatf("%s%s.result", tag, sel ? "_b" : "_a"), g_rs, rs);
    chk($sformatf("%s%s.game_over", tag, sel ? "_b" : "_a"), g_go, go);
    chk($sformatf("%s%s.busy", tag, sel ? "_b" : "_a"), g_bz, bz);
    chk($sformatf("%s%s.ack", tag, sel ? "_b" : "_a"), g_ak, ak);
    chk($sformatf("%s%s.rounds", tag, sel ? "_b" : "_a"), g_rn, rn);
  endtask

  // Called just after a falling edge; returns just after the falling edge that
  // follows e0 (the edge that samples the strobe).
  task automatic send(input logic [1:0] r, input int lvl);
    valid = 1'b1;
    res   = r;
    db    = '0;
    db[35:34] = 2'(lvl);
    @(negedge clk);
    valid = 1'b0;
    res   = 2'b00;
    db    = '0;
  endtask

  task automatic run_round(input logic [1:0] r, input int lvl);
    send(r, lvl);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; res = 2'b00; db = '0; restart = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_state("reset", 0, 10, 10, 0, 0, 0, 0, 0);
    chk_state("reset", 1, 10, 10, 0, 0, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);

    // Round 1 traced edge by edge: self wins, level 2
    send(2'b01, 2);
    chk_state("r1_e0", 0, 10, 10, 0, 0, 1, 0, 0);
    chk_state("r1_e0", 1, 10, 10, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk_state("r1_e1", 0, 10, 8, 0, 0, 1, 1, 1);
    chk_state("r1_e1", 1, 10, 8, 0, 0, 1, 1, 1);
    @(negedge clk);
    chk_state("r1_e2", 0, 10, 8, 0, 0, 0, 0, 1);
    chk_state("r1_e2", 1, 10, 8, 0, 0, 0, 0, 1);

    run_round(2'b10, 3);
    chk_state("r2", 0, 7, 8, 0, 0, 0, 0, 2);
    chk_state("r2", 1, 7, 8, 0, 0, 0, 0, 2);
    run_round(2'b10, 0);
    chk_state("r3_lvl0", 0, 6, 8, 0, 0, 0, 0, 3);
    chk_state("r3_lvl0", 1, 6, 8, 0, 0, 0, 0, 3);

    // Draw level 3: A ignores it, B hits both
    send(2'b11, 3);
    @(negedge clk);
    chk_state("r4_draw_e1", 0, 6, 8, 0, 0, 0, 0, 3);
    chk_state("r4_draw_e1", 1, 3, 5, 0, 0, 1, 1, 4);
    @(negedge clk);
    chk_state("r4_draw", 1, 3, 5, 0, 0, 0, 0, 4);

    run_round(2'b01, 3);
    chk_state("r5", 0, 6, 5, 0, 0, 0, 0, 4);
    chk_state("r5", 1, 3, 2, 0, 0, 0, 0, 5);
    run_round(2'b10, 1);
    chk_state("r6", 0, 5, 5, 0, 0, 0, 0, 5);
    chk_state("r6", 1, 2, 2, 0, 0, 0, 0, 6);
    run_round(2'b11, 2);
    chk_state("r7_dko", 0, 5, 5, 0, 0, 0, 0, 5);
    chk_state("r7_dko", 1, 0, 0, 3, 1, 1, 0, 7);

    run_round(2'b01, 2);
    chk_state("r8", 0, 5, 3, 0, 0, 0, 0, 6);
    chk_state("r8_frozen", 1, 0, 0, 3, 1, 1, 0, 7);
    run_round(2'b01, 2);
    chk_state("r9", 0, 5, 1, 0, 0, 0, 0, 7);

    // Enemy at 1 takes level 3: must floor at 0, not wrap to 14
    send(2'b01, 3);
    @(negedge clk);
    chk_state("r10_ko_e1", 0, 5, 0, 0, 0, 1, 1, 8);
    @(negedge clk);
    chk_state("r10_ko_e2", 0, 5, 0, 1, 1, 1, 0, 8);

    run_round(2'b01, 3);
    chk_state("over_ignore", 0, 5, 0, 1, 1, 1, 0, 8);
    chk_state("over_ignore", 1, 0, 0, 3, 1, 1, 0, 7);

    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk_state("restart_over", 0, 10, 10, 0, 0, 0, 0, 0);
    chk_state("restart_over", 1, 10, 10, 0, 0, 0, 0, 0);

    // Strobe held for e0 and e1: second one lands while busy and is dropped
    valid = 1'b1; res = 2'b01; db = '0; db[35:34] = 2'd2;
    @(negedge clk);
    @(negedge clk);
    valid = 1'b0; res = 2'b00; db = '0;
    chk_state("busy_drop_e1", 0, 10, 8, 0, 0, 1, 1, 1);
    @(negedge clk);
    @(negedge clk);
    chk_state("busy_drop", 0, 10, 8, 0, 0, 0, 0, 1);
    chk_state("busy_drop", 1, 10, 8, 0, 0, 0, 0, 1);

    restart = 1'b1; valid = 1'b1; res = 2'b10; db = '0; db[35:34] = 2'd3;
    @(negedge clk);
    restart = 1'b0; valid = 1'b0; res = 2'b00; db = '0;
    chk_state("restart_valid", 0, 10, 10, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk_state("restart_valid_late", 0, 10, 10, 0, 0, 0, 0, 0);
    chk_state("restart_valid_late", 1, 10, 10, 0, 0, 0, 0, 0);

    send(2'b01, 2);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk_state("restart_apply", 0, 10, 10, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk_state("restart_apply_late", 0, 10, 10, 0, 0, 0, 0, 0);
    chk_state("restart_apply_late", 1, 10, 10, 0, 0, 0, 0, 0);

    // Asynchronous reset between edges takes effect without a clock
    run_round(2'b10, 2);
    chk_state("pre_rst", 0, 8, 10, 0, 0, 0, 0, 1);
    send(2'b01, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_state("async_rst", 0, 10, 10, 0, 0, 0, 0, 0);
    chk_state("async_rst", 1, 10, 10, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_state("post_rst", 0, 10, 10, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
